// File: rtl/matmul_result_writeback_pkg.sv
// Shared definitions for the matmul result writeback block.
// Holds the default geometry of the matmul datapath and the FSM state encoding
// used by matmul_result_writeback.
package matmul_result_writeback_pkg;

  localparam int unsigned NumLanesDef    = 8;
  localparam int unsigned DWidthDef      = 16;
  localparam int unsigned RegIdWidthDef  = 8;
  localparam int unsigned Log2NumLanesDef = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StDrain   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/matmul_row_relu.sv
// Combinational per-row ReLU clamp.
// Ports:
//   en   - when 1, every negative lane is forced to zero
//   din  - NUMLANES signed elements of DWIDTH bits, lane 0 in the LSBs
//   dout - clamped row (equal to din when en=0)
module matmul_row_relu
  import matmul_result_writeback_pkg::*;
#(
  parameter int unsigned NUMLANES = NumLanesDef,
  parameter int unsigned DWIDTH   = DWidthDef
) (
  input  logic                       en,
  input  logic [NUMLANES*DWIDTH-1:0] din,
  output logic [NUMLANES*DWIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    for (int l = 0; l < int'(NUMLANES); l++) begin
      // Sign bit set means the element is negative.
      if (en && din[l*DWIDTH+DWIDTH-1]) begin
        dout[l*DWIDTH +: DWIDTH] = '0;
      end
    end
  end

endmodule

// File: rtl/matmul_result_writeback.sv
// Matmul result writeback.
// Captures NUMLANES result rows streamed by the matmul unit (one per cycle while
// c_data_avail is high), optionally clamps them with ReLU, then drains the rows
// selected by row_valid to the vector register file through a valid/ready port.
// Ports:
//   clk, resetn           - clock, synchronous active-low reset
//   start                 - latch in_dst/in_dst_we/vmask/row_valid/relu_en, arm capture
//   c_data, c_data_avail  - result row stream from the multiplier
//   out_*                 - writeback beat (data, dst = in_dst + row, row, we, mask)
//   busy                  - high whenever a command is in flight
//   done                  - one-cycle pulse after the command finishes
//   err                   - one-cycle pulse after a protocol violation
module matmul_result_writeback
  import matmul_result_writeback_pkg::*;
#(
  parameter int unsigned NUMLANES     = NumLanesDef,
  parameter int unsigned DWIDTH       = DWidthDef,
  parameter int unsigned REGIDWIDTH   = RegIdWidthDef,
  parameter int unsigned LOG2NUMLANES = Log2NumLanesDef
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [REGIDWIDTH-1:0]      in_dst,
  input  logic                       in_dst_we,
  input  logic [NUMLANES-1:0]        vmask,
  input  logic [NUMLANES-1:0]        row_valid,
  input  logic                       relu_en,
  input  logic [NUMLANES*DWIDTH-1:0] c_data,
  input  logic                       c_data_avail,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUMLANES*DWIDTH-1:0] out_data,
  output logic [REGIDWIDTH-1:0]      out_dst,
  output logic [LOG2NUMLANES-1:0]    out_row,
  output logic                       out_we,
  output logic [NUMLANES-1:0]        out_mask,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned RowW = NUMLANES * DWIDTH;
  localparam logic [LOG2NUMLANES-1:0] LastRow = LOG2NUMLANES'(NUMLANES - 1);

  wb_state_e state_q, state_d;

  logic [LOG2NUMLANES-1:0] cnt_q, cnt_d;
  logic [LOG2NUMLANES-1:0] ptr_q, ptr_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  // Command fields latched on start.
  logic [REGIDWIDTH-1:0] dst_q;
  logic                  we_q;
  logic [NUMLANES-1:0]   mask_q;
  logic [NUMLANES-1:0]   rv_q;
  logic                  relu_q;

  logic [RowW-1:0] buf_q [NUMLANES];
  logic [RowW-1:0] relu_row;

  logic [LOG2NUMLANES-1:0] first_idx;
  logic [LOG2NUMLANES-1:0] next_idx;
  logic                    has_next;

  matmul_row_relu #(
    .NUMLANES (NUMLANES),
    .DWIDTH   (DWIDTH)
  ) u_row_relu (
    .en   (relu_q),
    .din  (c_data),
    .dout (relu_row)
  );

  // Lowest valid row overall, and lowest valid row strictly above the drain pointer.
  // Scanning downwards lets the last hit win, which is the lowest index.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = int'(NUMLANES) - 1; i >= 0; i--) begin
      if (rv_q[i]) begin
        first_idx = LOG2NUMLANES'(i);
        if (i > int'(ptr_q)) begin
          next_idx = LOG2NUMLANES'(i);
          has_next = 1'b1;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Command latch; only updated when a command is accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dst_q  <= '0;
      we_q   <= 1'b0;
      mask_q <= '0;
      rv_q   <= '0;
      relu_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      dst_q  <= in_dst;
      we_q   <= in_dst_we;
      mask_q <= vmask;
      rv_q   <= row_valid;
      relu_q <= relu_en;
    end
  end

  // Row buffer; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == StCapture && c_data_avail) begin
      buf_q[cnt_q] <= relu_row;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A row arriving with no command armed is dropped.
        if (c_data_avail) err_d = 1'b1;
        if (start) begin
          state_d = StCapture;
          cnt_d   = '0;
        end
      end
      StCapture: begin
        if (start) err_d = 1'b1;
        if (c_data_avail) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastRow) begin
            cnt_d = '0;
            if (rv_q == '0) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StDrain;
              ptr_d   = first_idx;
            end
          end
        end
      end
      StDrain: begin
        if (start || c_data_avail) err_d = 1'b1;
        if (out_ready) begin
          if (has_next) begin
            ptr_d = next_idx;
          end else begin
            state_d = StIdle;
            ptr_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; beat fields are forced to zero outside DRAIN so nothing leaks from the buffer.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_dst   = '0;
    out_row   = '0;
    out_we    = 1'b0;
    out_mask  = '0;
    if (state_q == StDrain) begin
      out_valid = 1'b1;
      out_data  = buf_q[ptr_q];
      out_dst   = dst_q + REGIDWIDTH'(ptr_q);
      out_row   = ptr_q;
      out_we    = we_q;
      out_mask  = mask_q;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_matmul_result_writeback.sv
module tb_matmul_result_writeback;

  localparam int NL   = 8;
  localparam int DW   = 16;
  localparam int RW   = 8;
  localparam int LW   = 3;
  localparam int ROWW = NL * DW;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic [RW-1:0]   in_dst = '0;
  logic            in_dst_we = 1'b0;
  logic [NL-1:0]   vmask = '0;
  logic [NL-1:0]   row_valid = '0;
  logic            relu_en = 1'b0;
  logic [ROWW-1:0] c_data = '0;
  logic            c_data_avail = 1'b0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [ROWW-1:0] out_data;
  logic [RW-1:0]   out_dst;
  logic [LW-1:0]   out_row;
  logic            out_we;
  logic [NL-1:0]   out_mask;
  logic            busy;
  logic            done;
  logic            err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ROWW-1:0] data;
    logic [RW-1:0]   dst;
    logic [LW-1:0]   row;
  } beat_t;

  beat_t exp_q[$];

  matmul_result_writeback dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .in_dst       (in_dst),
    .in_dst_we    (in_dst_we),
    .vmask        (vmask),
    .row_valid    (row_valid),
    .relu_en      (relu_en),
    .c_data       (c_data),
    .c_data_avail (c_data_avail),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_dst      (out_dst),
    .out_row      (out_row),
    .out_we       (out_we),
    .out_mask     (out_mask),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk(input logic v, input logic [ROWW-1:0] d,
                                      input logic [RW-1:0] dst, input logic [LW-1:0] row,
                                      input logic we, input logic [NL-1:0] m, input logic b,
                                      input logic dn, input logic e);
    return 256'({v, d, dst, row, we, m, b, dn, e});
  endfunction

  function automatic logic [255:0] obs();
    return 256'({out_valid, out_data, out_dst, out_row, out_we, out_mask, busy, done, err});
  endfunction

  task automatic check(input string tag, input logic [255:0] o, input logic [255:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, o, e);
      $error("check %s differs", tag);
    end
  endtask

  // ready_mode: 0 always ready, 1 alternating 1,0,1,0..., 2 random.
  // viol: 0 none, 1 start+c_data_avail on first drain cycle, 2 start on final beat.
  task automatic run_cmd(input logic [RW-1:0] dst, input logic we, input logic [NL-1:0] mask,
                         input logic [NL-1:0] rv, input logic relu, input int ready_mode,
                         input bit gaps, input int viol, input bit pat);
    logic [ROWW-1:0] rows[NL];
    logic [DW-1:0]   e;
    beat_t           b;
    int              guard;
    bit              rdy;
    bit              exp_err;

    for (int r = 0; r < NL; r++) begin
      rows[r] = {$urandom, $urandom, $urandom, $urandom};
      if (pat) begin
        rows[r][0 +: DW]    = 16'hFFFF;
        rows[r][5*DW +: DW] = 16'h0005;
      end
    end

    // Reference: every selected row in ascending order, clamped if requested.
    exp_q.delete();
    for (int r = 0; r < NL; r++) begin
      if (rv[r]) begin
        b.data = rows[r];
        if (relu) begin
          for (int l = 0; l < NL; l++) begin
            e = b.data[l*DW +: DW];
            if ($signed(e) < 0) b.data[l*DW +: DW] = '0;
          end
        end
        b.dst = RW'(dst + RW'(r));
        b.row = LW'(r);
        exp_q.push_back(b);
      end
    end

    start = 1'b1; in_dst = dst; in_dst_we = we; vmask = mask; row_valid = rv; relu_en = relu;
    tick();
    start = 1'b0;
    // Scramble command inputs: the block must use the latched copies.
    in_dst = ~dst; in_dst_we = ~we; vmask = ~mask; row_valid = ~rv; relu_en = ~relu;
    check("cmd_accept", obs(), mk(0, '0, '0, '0, 0, '0, 1, 0, 0));

    for (int r = 0; r < NL; r++) begin
      if (gaps && $urandom_range(1, 0) == 1) begin
        c_data_avail = 1'b0;
        c_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        check("capture_gap", obs(), mk(0, '0, '0, '0, 0, '0, 1, 0, 0));
      end
      c_data = rows[r];
      c_data_avail = 1'b1;
      tick();
      if (r < NL - 1) check("capture_row", obs(), mk(0, '0, '0, '0, 0, '0, 1, 0, 0));
    end
    c_data_avail = 1'b0;

    exp_err = 1'b0;
    if (rv == '0) begin
      check("empty_done", obs(), mk(0, '0, '0, '0, 0, '0, 0, 1, 0));
    end else begin
      guard = 0;
      while (exp_q.size() > 0 && guard < 200) begin
        b = exp_q[0];
        check("drain_beat", obs(), mk(1, b.data, b.dst, b.row, we, mask, 1, 0, exp_err));
        if (ready_mode == 0) rdy = 1'b1;
        else if (ready_mode == 1) rdy = (guard % 2 == 0);
        else rdy = ($urandom_range(1, 0) == 1);
        exp_err = 1'b0;
        if (viol == 1 && guard == 0) begin
          start = 1'b1; c_data_avail = 1'b1; rdy = 1'b0; exp_err = 1'b1;
        end
        if (viol == 2 && exp_q.size() == 1 && rdy) begin
          start = 1'b1; exp_err = 1'b1;
        end
        out_ready = rdy;
        tick();
        start = 1'b0;
        c_data_avail = 1'b0;
        if (rdy) void'(exp_q.pop_front());
        guard++;
      end
      if (exp_q.size() > 0) check("drain_timeout", 256'(exp_q.size()), 256'(0));
      check("drain_done", obs(), mk(0, '0, '0, '0, 0, '0, 0, 1, exp_err));
    end
    out_ready = 1'b0;
    tick();
    check("post_idle", obs(), mk(0, '0, '0, '0, 0, '0, 0, 0, 0));
  endtask

  initial begin
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_reset", obs(), mk(0, '0, '0, '0, 0, '0, 0, 0, 0));
    end

    // Full drain, always ready.
    run_cmd(8'h10, 1'b1, 8'hFF, 8'hFF, 1'b0, 0, 1'b0, 0, 1'b0);
    // Sparse rows with stalls.
    run_cmd(8'h20, 1'b1, 8'h5A, 8'b1010_0101, 1'b0, 1, 1'b1, 0, 1'b0);
    // ReLU with known lane values.
    run_cmd(8'h30, 1'b1, 8'hFF, 8'hFF, 1'b1, 0, 1'b0, 0, 1'b1);

    // Row arriving while idle.
    c_data_avail = 1'b1;
    c_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    c_data_avail = 1'b0;
    check("idle_avail_err", obs(), mk(0, '0, '0, '0, 0, '0, 0, 0, 1));
    tick();
    check("idle_avail_clear", obs(), mk(0, '0, '0, '0, 0, '0, 0, 0, 0));

    // Protocol violations during drain.
    run_cmd(8'h40, 1'b0, 8'h0F, 8'hC3, 1'b0, 0, 1'b0, 1, 1'b0);
    run_cmd(8'h50, 1'b1, 8'hF0, 8'h81, 1'b1, 0, 1'b0, 2, 1'b0);
    // No valid rows.
    run_cmd(8'h60, 1'b1, 8'hAA, 8'h00, 1'b0, 0, 1'b1, 0, 1'b0);

    // Reset in the middle of capture.
    start = 1'b1; in_dst = 8'h70; in_dst_we = 1'b1; vmask = 8'hFF; row_valid = 8'hFF;
    tick();
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      c_data = {$urandom, $urandom, $urandom, $urandom};
      c_data_avail = 1'b1;
      tick();
    end
    c_data_avail = 1'b0;
    resetn = 1'b0;
    tick();
    check("mid_reset", obs(), mk(0, '0, '0, '0, 0, '0, 0, 0, 0));
    resetn = 1'b1;
    tick();
    check("mid_reset_idle", obs(), mk(0, '0, '0, '0, 0, '0, 0, 0, 0));
    // Destination wrap.
    run_cmd(8'hFE, 1'b1, 8'hFF, 8'hFF, 1'b0, 0, 1'b0, 0, 1'b0);

    // Randomized commands.
    for (int k = 0; k < 6; k++) begin
      run_cmd(RW'($urandom), 1'($urandom), NL'($urandom), NL'($urandom), 1'($urandom),
              2, 1'b1, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_result_writeback.md
Name: matmul_result_writeback

Overview:
- Sits directly downstream of the matmul unit in the vector processor.
- Captures the NUMLANES result rows the matrix multiplier streams out while its data-available flag is high, one row per cycle.
- Optionally applies ReLU, then drains the rows one per beat to the vector register file writeback port through a valid/ready handshake, with destination, row index and lane mask.
- Raises busy so the issue stage stalls until every valid row has been written back.

Parameters:
NUMLANES, 8, lanes = matrix dimension; rows per result
DWIDTH, 16, element width (signed two's complement)
REGIDWIDTH, 8, vector register id width
LOG2NUMLANES, 3, row index width

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
start  in  1  latch command fields, arm capture
in_dst  in  REGIDWIDTH  base destination register
in_dst_we  in  1  writeback enable for this command
vmask  in  NUMLANES  lane mask applied to every row
row_valid  in  NUMLANES  per-row validity (bit r = row r)
relu_en  in  1  clamp negative elements to 0
c_data  in  NUMLANES*DWIDTH  result row from multiplier, lane 0 in LSBs
c_data_avail  in  1  c_data holds a valid row this cycle
out_valid  out  1  writeback beat valid
out_ready  in  1  register file accepts beat
out_data  out  NUMLANES*DWIDTH  row data
out_dst  out  REGIDWIDTH  in_dst + row index (mod 2^REGIDWIDTH)
out_row  out  LOG2NUMLANES  row index
out_we  out  1  latched in_dst_we
out_mask  out  NUMLANES  latched vmask
busy  out  1  block not IDLE
done  out  1  one-cycle pulse when command finished
err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; capture/drain counters 0; all outputs 0; buffer contents don't-care.
- Reset mid-operation discards the command; no done pulse.
- States:
  - IDLE: start=1 -> latch in_dst, in_dst_we, vmask, row_valid, relu_en; capture count := 0; go to CAPTURE. busy=1 from the following cycle.
  - CAPTURE: each cycle with c_data_avail=1, store c_data (ReLU applied if latched relu_en) into buffer[count] and increment count. Gaps (c_data_avail=0) are allowed; wait without a timeout. After row NUMLANES-1 is stored -> DRAIN, drain pointer := lowest set bit of the latched row_valid.
  - DRAIN: out_valid=1 with buffer[ptr]. A beat transfers when out_valid & out_ready. On transfer, ptr advances to the next set row_valid bit. After the last valid row transfers -> IDLE and done=1 that same cycle as registered.
- Latched row_valid = 0: still capture all NUMLANES rows, then go directly to IDLE with done; no out_valid.
- Latency: first out_valid asserts the cycle after the last row is captured. With out_ready tied 1, a full drain takes NUMLANES cycles.
- out_data, out_dst, out_row, out_we and out_mask are held stable while out_valid=1 and out_ready=0.
- out_we and out_mask are constant across all beats of one command.
- ReLU: element[DWIDTH-1]=1 -> 0, otherwise unchanged; applied per lane at capture time.
- Err conditions (each pulses err for one cycle):
  - c_data_avail=1 in IDLE or DRAIN: row dropped.
  - start=1 while busy: ignored, current command unaffected.
- start and a final drain beat in the same cycle: start is ignored (state still DRAIN) and err pulses.
- out_dst wraps modulo 2^REGIDWIDTH.

Decomposition:
- Shared package/header: DWIDTH, NUMLANES, LOG2NUMLANES, REGIDWIDTH defaults; state encoding IDLE=2'd0, CAPTURE=2'd1, DRAIN=2'd2.
- One sub-module: matmul_row_relu, a combinational per-row clamp (NUMLANES*DWIDTH in/out, enable).
- Buffer is a NUMLANES x (NUMLANES*DWIDTH) register array, no RAM macro.

Test Plan:
- Reset then idle, c_data_avail=0 -> all outputs 0, busy=0 for 20 cycles.
- start with in_dst=8'h10, row_valid=8'hFF, relu_en=0; 8 rows avail back-to-back; out_ready=1 -> 8 beats out_dst 0x10..0x17 with matching rows; done on the last beat's retire; busy drops the next cycle.
- row_valid=8'b1010_0101, out_ready toggling 1,0,1,0 -> only rows 0,2,5,7 emitted in order; outputs stable while stalled; done after row 7.
- relu_en=1, row lane values 16'hFFFF and 16'h0005 -> out lanes 0 and 5.
- c_data_avail=1 while IDLE, and start while DRAIN -> err pulses once each, state and outputs unaffected.
- resetn=0 during CAPTURE after 3 rows -> IDLE, no done; a new command with in_dst=8'hFE completes with out_dst wrapping 0xFE,0xFF,0x00...
